// File: rtl/banco_fifos.sv
// banco_fifos: bank of four independent circular FIFOs (one per lane).
// Ports: clk, reset_L (async active-low); per lane N=0..3:
//   valid_inN/inN push, popN pop request, outN/valid_outN registered pop data,
//   emptyN/fullN/almost_emptyN/almost_fullN occupancy flags from the count.
//   IDLE = all lanes empty; err = sticky overflow/underflow flag.
// Optional feature: define BANCO_FIFOS_ERR_EN to enable err; otherwise err = 0.
module banco_fifos #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 2,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic                  valid_in3,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic                  pop0,
    input  logic                  pop1,
    input  logic                  pop2,
    input  logic                  pop3,
    output logic [DATA_WIDTH-1:0] out0,
    output logic [DATA_WIDTH-1:0] out1,
    output logic [DATA_WIDTH-1:0] out2,
    output logic [DATA_WIDTH-1:0] out3,
    output logic                  valid_out0,
    output logic                  valid_out1,
    output logic                  valid_out2,
    output logic                  valid_out3,
    output logic                  empty0,
    output logic                  empty1,
    output logic                  empty2,
    output logic                  empty3,
    output logic                  full0,
    output logic                  full1,
    output logic                  full2,
    output logic                  full3,
    output logic                  almost_empty0,
    output logic                  almost_empty1,
    output logic                  almost_empty2,
    output logic                  almost_empty3,
    output logic                  almost_full0,
    output logic                  almost_full1,
    output logic                  almost_full2,
    output logic                  almost_full3,
    output logic                  IDLE,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

    logic [3:0]                 push_req;
    logic [3:0]                 pop_req;
    logic [3:0][DATA_WIDTH-1:0] din;
    logic [3:0][DATA_WIDTH-1:0] dout;
    logic [3:0]                 vout;
    logic [3:0]                 l_empty;
    logic [3:0]                 l_full;
    logic [3:0]                 l_aempty;
    logic [3:0]                 l_afull;

    assign push_req = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign pop_req  = {pop3, pop2, pop1, pop0};
    assign din      = {in3, in2, in1, in0};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
        logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         cnt_q, cnt_d;
        logic [DATA_WIDTH-1:0] out_q;
        logic                  vout_q;
        logic                  push_ok;
        logic                  pop_ok;

        assign l_empty[i]  = (cnt_q == '0);
        assign l_full[i]   = (cnt_q == DEPTH_C);
        assign l_aempty[i] = (cnt_q <= AE_C);
        assign l_afull[i]  = (cnt_q >= AF_C);

        // A full lane still accepts a push when a pop frees a slot on
        // the same edge; an empty lane never bypasses push data to out.
        assign pop_ok  = pop_req[i] & ~l_empty[i];
        assign push_ok = push_req[i] & (~l_full[i] | pop_req[i]);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Storage is not reset: the pointers and count define validity.
        always_ff @(posedge clk) begin
            if (push_ok) mem[wr_ptr_q] <= din[i];
        end

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                out_q    <= '0;
                vout_q   <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                vout_q   <= pop_ok;
                if (pop_ok) out_q <= mem[rd_ptr_q];
            end
        end

        assign dout[i] = out_q;
        assign vout[i] = vout_q;
    end

`ifdef BANCO_FIFOS_ERR_EN
    logic [3:0] drop;
    logic [3:0] udf;
    logic       err_q;

    // Overflow: push dropped on a full lane. Underflow: pop on an empty
    // lane, except when a push lands on that lane on the same edge.
    assign drop = push_req & l_full & ~pop_req;
    assign udf  = pop_req & l_empty & ~push_req;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_q <= 1'b0;
        end else if (|{drop, udf}) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out0 = dout[0];
    assign out1 = dout[1];
    assign out2 = dout[2];
    assign out3 = dout[3];

    assign valid_out0 = vout[0];
    assign valid_out1 = vout[1];
    assign valid_out2 = vout[2];
    assign valid_out3 = vout[3];

    assign empty0 = l_empty[0];
    assign empty1 = l_empty[1];
    assign empty2 = l_empty[2];
    assign empty3 = l_empty[3];

    assign full0 = l_full[0];
    assign full1 = l_full[1];
    assign full2 = l_full[2];
    assign full3 = l_full[3];

    assign almost_empty0 = l_aempty[0];
    assign almost_empty1 = l_aempty[1];
    assign almost_empty2 = l_aempty[2];
    assign almost_empty3 = l_aempty[3];

    assign almost_full0 = l_afull[0];
    assign almost_full1 = l_afull[1];
    assign almost_full2 = l_afull[2];
    assign almost_full3 = l_afull[3];

    assign IDLE = &l_empty;

endmodule

// File: tb/tb_banco_fifos.sv
// tb_banco_fifos: queue-based reference model of four FIFO lanes,
// directed scenarios with literal expectations, then random traffic.
module tb_banco_fifos;

`ifdef BANCO_FIFOS_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] vin;
    logic [3:0] pop;
    logic [7:0] din [4];

    logic [7:0] out0, out1, out2, out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       empty0, empty1, empty2, empty3;
    logic       full0, full1, full2, full3;
    logic       ae0, ae1, ae2, ae3;
    logic       af0, af1, af2, af3;
    logic       IDLE, err;

    logic [7:0] dout [4];
    logic [3:0] vo, emp, ful, aem, afu;

    assign dout[0] = out0;
    assign dout[1] = out1;
    assign dout[2] = out2;
    assign dout[3] = out3;
    assign vo  = {valid_out3, valid_out2, valid_out1, valid_out0};
    assign emp = {empty3, empty2, empty1, empty0};
    assign ful = {full3, full2, full1, full0};
    assign aem = {ae3, ae2, ae1, ae0};
    assign afu = {af3, af2, af1, af0};

    always #5 clk = ~clk;

    banco_fifos dut (
        .clk(clk), .reset_L(reset_L),
        .valid_in0(vin[0]), .valid_in1(vin[1]),
        .valid_in2(vin[2]), .valid_in3(vin[3]),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .valid_out2(valid_out2), .valid_out3(valid_out3),
        .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
        .full0(full0), .full1(full1), .full2(full2), .full3(full3),
        .almost_empty0(ae0), .almost_empty1(ae1),
        .almost_empty2(ae2), .almost_empty3(ae3),
        .almost_full0(af0), .almost_full1(af1),
        .almost_full2(af2), .almost_full3(af3),
        .IDLE(IDLE), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per lane.
    logic [7:0] mq [4][$];
    logic [7:0] m_out [4] = '{default: 8'h00};
    logic [3:0] m_vout = 4'b0;
    logic       m_err = 1'b0;

    always @(posedge clk or negedge reset_L) begin
        int sz;
        bit pok, wok;
        if (!reset_L) begin
            for (int l = 0; l < 4; l++) begin
                mq[l].delete();
                m_out[l] = 8'h00;
            end
            m_vout = 4'b0;
            m_err  = 1'b0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                sz  = mq[l].size();
                pok = pop[l] && (sz > 0);
                wok = vin[l] && ((sz < 4) || pop[l]);
                if ((vin[l] && sz == 4 && !pop[l]) ||
                    (pop[l] && sz == 0 && !vin[l]))
                    m_err = ERR_EXP;
                m_vout[l] = pok;
                if (pok) m_out[l] = mq[l].pop_front();
                if (wok) mq[l].push_back(din[l]);
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        bit all_e;
        all_e = 1'b1;
        for (int l = 0; l < 4; l++) begin
            sz = mq[l].size();
            if (sz != 0) all_e = 1'b0;
            chk($sformatf("out%0d", l), 32'(dout[l]), 32'(m_out[l]));
            chk($sformatf("valid_out%0d", l), 32'(vo[l]), 32'(m_vout[l]));
            chk($sformatf("empty%0d", l), 32'(emp[l]), 32'(sz == 0));
            chk($sformatf("full%0d", l), 32'(ful[l]), 32'(sz == 4));
            chk($sformatf("almost_empty%0d", l), 32'(aem[l]), 32'(sz <= 1));
            chk($sformatf("almost_full%0d", l), 32'(afu[l]), 32'(sz >= 3));
        end
        chk("IDLE", 32'(IDLE), 32'(all_e));
        chk("err", 32'(err), 32'(m_err));
    end

    // Applies one edge of stimulus on one lane, then returns 2ns after it.
    task automatic lane_op(input int l, input bit v, input bit p,
                           input logic [7:0] d);
        vin = '0;
        pop = '0;
        vin[l] = v;
        pop[l] = p;
        din[l] = d;
        @(posedge clk);
        #2;
        vin = '0;
        pop = '0;
    endtask

    task automatic all_op(input logic [3:0] v, input logic [3:0] p);
        vin = v;
        pop = p;
        for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
        @(posedge clk);
        #2;
        vin = '0;
        pop = '0;
    endtask

    task automatic pulse_reset();
        reset_L = 1'b0;
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_b;
        reset_L = 1'b0;
        vin = '0;
        pop = '0;
        for (int l = 0; l < 4; l++) din[l] = 8'h00;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst IDLE", 32'(IDLE), 32'h1);
        chk("rst empty", 32'(emp), 32'hF);
        chk("rst valid_out", 32'(vo), 32'h0);
        chk("rst out0", 32'(out0), 32'h0);
        chk("rst out3", 32'(out3), 32'h0);
        chk("rst err", 32'(err), 32'h0);
        chk("rst almost_empty", 32'(aem), 32'hF);
        chk("rst full", 32'(ful), 32'h0);
        @(posedge clk);
        #2;
        reset_L = 1'b1;

        // Lane 0 fill and drain
        lane_op(0, 1, 0, 8'h11);
        lane_op(0, 1, 0, 8'h22);
        lane_op(0, 1, 0, 8'h33);
        chk("l0 af after 3", 32'(af0), 32'h1);
        chk("l0 full after 3", 32'(full0), 32'h0);
        lane_op(0, 1, 0, 8'h44);
        chk("l0 full after 4", 32'(full0), 32'h1);
        chk("l0 IDLE busy", 32'(IDLE), 32'h0);
        for (int k = 0; k < 4; k++) begin
            lane_op(0, 0, 1, 8'h00);
            exp_b = 8'h11 * 8'(k + 1);
            chk("l0 pop data", 32'(out0), 32'(exp_b));
            chk("l0 pop valid", 32'(valid_out0), 32'h1);
        end
        chk("l0 empty drained", 32'(empty0), 32'h1);
        chk("l0 IDLE drained", 32'(IDLE), 32'h1);

        // Lane 2 overflow
        for (int k = 0; k < 4; k++) lane_op(2, 1, 0, 8'hA0 + 8'(k));
        lane_op(2, 1, 0, 8'h55);
        chk("l2 full after drop", 32'(full2), 32'h1);
        chk("l2 err after drop", 32'(err), 32'(ERR_EXP));
        for (int k = 0; k < 4; k++) begin
            lane_op(2, 0, 1, 8'h00);
            chk("l2 pop data", 32'(out2), 32'(8'hA0 + 8'(k)));
        end
        chk("l2 empty", 32'(empty2), 32'h1);

        @(posedge clk);
        #2;
        pulse_reset();
        chk("err cleared", 32'(err), 32'h0);

        // Lane 1 full push+pop, wrap-around
        for (int k = 0; k < 4; k++) lane_op(1, 1, 0, 8'hB0 + 8'(k));
        lane_op(1, 1, 1, 8'hAA);
        chk("l1 pp data", 32'(out1), 32'hB0);
        chk("l1 pp full", 32'(full1), 32'h1);
        for (int k = 1; k < 4; k++) begin
            lane_op(1, 0, 1, 8'h00);
            chk("l1 pop data", 32'(out1), 32'(8'hB0 + 8'(k)));
        end
        lane_op(1, 0, 1, 8'h00);
        chk("l1 last AA", 32'(out1), 32'hAA);

        // Lane 3 empty push+pop
        lane_op(3, 1, 1, 8'h7E);
        chk("l3 no bypass", 32'(valid_out3), 32'h0);
        chk("l3 err unchanged", 32'(err), 32'h0);
        chk("l3 count1 ae", 32'(ae3), 32'h1);
        chk("l3 not empty", 32'(empty3), 32'h0);
        lane_op(3, 0, 1, 8'h00);
        chk("l3 pop 7E", 32'(out3), 32'h7E);
        chk("l3 pop valid", 32'(valid_out3), 32'h1);

        // Mid-operation reset with two words per lane
        all_op(4'hF, 4'h0);
        all_op(4'hF, 4'h0);
        all_op(4'hF, 4'h0);
        all_op(4'h0, 4'hF);
        chk("pre-rst valid", 32'(vo), 32'hF);
        chk("pre-rst IDLE", 32'(IDLE), 32'h0);
        reset_L = 1'b0;
        #1;
        chk("mid-rst empty", 32'(emp), 32'hF);
        chk("mid-rst IDLE", 32'(IDLE), 32'h1);
        chk("mid-rst valid", 32'(vo), 32'h0);
        reset_L = 1'b1;
        all_op(4'h0, 4'hF);
        chk("post-rst pop", 32'(vo), 32'h0);

        // Random traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r1, r2;
            r1 = 4'($urandom);
            r2 = 4'($urandom);
            unique case ((c / 300) % 3)
                0: begin vin = r1; pop = r2; end
                1: begin vin = r1 | r2; pop = r1 & r2; end
                default: begin vin = r1 & r2; pop = r1 | r2; end
            endcase
            for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
            @(posedge clk);
            #2;
            if ($urandom_range(0, 249) == 0) pulse_reset();
        end
        vin = '0;
        pop = '0;
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/banco_fifos.md
BANCO_FIFOS -- requirements
Module: banco_fifos

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, lane data width.
REQ-002 Parameter: ADDR_WIDTH, default 2, FIFO depth = 2**ADDR_WIDTH = 4 entries per lane.
REQ-003 Parameter: ALMOST_FULL, default 3, almost_full threshold (count >= ALMOST_FULL).
REQ-004 Parameter: ALMOST_EMPTY, default 1, almost_empty threshold (count <= ALMOST_EMPTY).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low. Ports: clk input 1, rising-edge clock; reset_L input 1, asynchronous active-low reset.
REQ-006 Port: valid_in0..valid_in3, input, 1 each, push request per lane, driven by the recirculation stage's valid_outp0..3.
REQ-007 Port: in0..in3, input, DATA_WIDTH each, push data per lane, driven by the recirculation stage's outp0..3.
REQ-008 Port: pop0..pop3, input, 1 each, pop request per lane.
REQ-009 Port: out0..out3, output, DATA_WIDTH each, registered popped data.
REQ-010 Port: valid_out0..valid_out3, output, 1 each, outN holds a word popped last cycle.
REQ-011 Port: empty0..3 / full0..3, output, 1 each, lane occupancy flags.
REQ-012 Port: almost_empty0..3 / almost_full0..3, output, 1 each, threshold flags.
REQ-013 Port: IDLE, output, 1, all four lanes empty; fed back to the recirculation stage's IDLE input.
REQ-014 Port: err, output, 1, sticky overflow/underflow flag (see Configuration).

Function
REQ-015 Each lane SHALL be an independent circular FIFO with write pointer, read pointer (ADDR_WIDTH bits, natural wrap 3->0) and count (ADDR_WIDTH+1 bits, 0..4).
REQ-016 Push: on a clk edge with valid_inN=1 and fullN=0, inN SHALL be written at wr_ptr, wr_ptr +1, count +1.
REQ-017 Pop: on a clk edge with popN=1 and emptyN=0, outN SHALL load mem[rd_ptr] and valid_outN SHALL be 1 for that cycle; rd_ptr +1, count -1; latency pop->data = 1 cycle.
REQ-018 If popN=0 or emptyN=1, valid_outN SHALL be 0 next cycle and outN SHALL hold its previous value.
REQ-019 Simultaneous push+pop on a non-empty lane (including full) SHALL both succeed; count unchanged.
REQ-020 Simultaneous push+pop on an empty lane: push SHALL succeed, pop SHALL be ignored (no bypass), valid_outN=0.
REQ-021 Push on a full lane without pop SHALL be dropped; memory and pointers unchanged.
REQ-022 Flags SHALL be combinational from count: empty=(count==0), full=(count==4), almost_empty=(count<=ALMOST_EMPTY), almost_full=(count>=ALMOST_FULL).
REQ-023 IDLE SHALL be combinational AND of empty0..empty3.

Reset
REQ-024 On reset_L=0, asynchronously: all pointers and counts 0, out0..3=0, valid_out0..3=0, err=0.
REQ-025 Resulting flags during/after reset: empty=1, almost_empty=1, full=0, almost_full=0, IDLE=1; memory contents need not be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; the first clk edge after deassertion SHALL behave as on an empty bank.

Configuration
REQ-027 Macro BANCO_FIFOS_ERR_EN defined: err SHALL set on any dropped push (REQ-021) or any pop on an empty lane (excluding REQ-020), and stay 1 until reset.
REQ-028 Macro BANCO_FIFOS_ERR_EN undefined: err SHALL be tied 0; drop/ignore behaviour otherwise identical.

Verification
REQ-029 Reset: reset_L=0 -> IDLE=1, empty0..3=1, valid_out0..3=0, out0..3=0, err=0.
REQ-030 Lane 0 push 0x11,0x22,0x33,0x44 on 4 edges -> full0=1, almost_full0=1 after 3rd, IDLE=0; then pop0 x4 -> out0 0x11..0x44 one cycle after each pop, empty0=1, IDLE=1.
REQ-031 Lane 2 full, push 0x55 without pop -> word dropped, count stays 4, err=1 (with macro) / err=0 (without); subsequent pops return original 4 words.
REQ-032 Lane 1 full, push 0xAA and pop same edge -> out1=oldest word, full1 stays 1, 0xAA popped last after 3 more pops (wrap-around exercised).
REQ-033 Empty lane 3, push 0x7E with pop3 same edge -> valid_out3=0, err unchanged, count=1; next pop3 -> out3=0x7E.
REQ-034 All lanes holding 2 words, reset_L pulsed low between edges -> immediate empty=1, IDLE=1, valid_out=0; next pop returns nothing.
